fsm_seq_det: RTL and testbench

FSM_SEQ_DET -- requirements
Module: fsm_seq_det

---
 rtl/fsm_pkg.sv | 53 +++++
 rtl/sat_counter.sv | 57 +++++
 rtl/fsm_seq_det.sv | 89 ++++++++
 tb/tb_fsm_seq_det.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// fsm_pkg
// Shared definitions for the serial sequence detector.
//   state_t      : registered state vector. The value is the length of the
//                  currently matched pattern prefix (0 = P0 .. PAT_W = MATCH).
//   ST_P0        : idle / nothing matched.
//   DEF_PAT_W    : default pattern length.
//   DEF_PATTERN  : default pattern, MSB is the first bit received.
//   prefixNext() : elaboration-time helper that builds the next-state map.
package fsm_pkg;

  localparam int MAX_PAT_W = 16;
  localparam int STATE_W   = 5;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_P0 = 5'd0;

  localparam int                   DEF_PAT_W   = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1011;

  // Longest pattern prefix that is a suffix of (top k pattern bits, then b).
  // Everything is kept right-aligned in 32-bit words so the comparison is a
  // plain masked equality; the first bit received sits at the highest index.
  // Result is clamped to patW, so a full match from MATCH stays at MATCH
  // (the overlapping case) or falls back to a shorter border.
  function automatic state_t prefixNext(input logic [31:0] pat,
                                        input int          patW,
                                        input int          k,
                                        input logic        b);
    logic [31:0] hist;
    logic [31:0] mask;
    logic [31:0] head;
    int          lim;
    logic        found;
    state_t      res;
    hist  = ((pat >> (patW - k)) << 1) | {31'd0, b};
    lim   = (k + 1 < patW) ? k + 1 : patW;
    res   = ST_P0;
    found = 1'b0;
    for (int j = MAX_PAT_W; j >= 1; j--) begin
      if (!found && j <= lim) begin
        mask = (32'd1 << j) - 32'd1;
        head = pat >> (patW - j);
        if ((hist & mask) == head) begin
          res   = state_t'(j);
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter with a sticky saturation flag.
//   clk    : clock, rising edge
//   areset : asynchronous active-high reset
//   clr    : synchronous clear of count and sat (wins over inc)
//   inc    : count one event this edge
//   count  : current count, stops at all-ones
//   sat    : set when an event arrives while count is already all-ones,
//            held until clr or areset
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             sat_q;
  logic             sat_d;

  // An event at full scale leaves the count alone and raises the sticky flag.
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clr) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (inc) begin
      if (count_q == CNT_MAX) begin
        sat_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/fsm_seq_det.sv
// fsm_seq_det
// Serial pattern detector, Moore style, with a saturating match counter.
// Parameters:
//   PAT_W   : pattern length (2..16)
//   PATTERN : pattern, PATTERN[PAT_W-1] is received first
//   OVERLAP : 1 = overlapping matches count, 0 = matches must not share bits
//   CNT_W   : match counter width (2..32)
// Ports:
//   clk         : clock, rising edge
//   areset      : asynchronous active-high reset
//   en          : in is consumed only when en=1
//   clr         : synchronous clear of state and counters, beats en
//   in          : serial data bit
//   out         : high while the FSM sits in MATCH
//   match_count : number of matches seen, saturating
//   count_sat   : sticky, a match arrived while match_count was full
module fsm_seq_det
  import fsm_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             en,
  input  logic             clr,
  input  logic             in,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam logic [31:0] PAT32    = 32'(PATTERN);
  localparam state_t      ST_MATCH = state_t'(PAT_W);

  state_t state_q;
  state_t state_d;
  logic   matchInc;

  // The state value is the matched prefix length, so each branch of the loop
  // resolves to a constant pair of successors selected by in. Leaving MATCH
  // without overlap restarts from an empty prefix. Encodings above PAT_W are
  // unreachable and fall back to P0.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_P0;
    end else if (en) begin
      state_d = ST_P0;
      for (int k = 0; k <= PAT_W; k++) begin
        if (state_q == state_t'(k)) begin
          if (k == PAT_W && !OVERLAP) begin
            state_d = prefixNext(PAT32, PAT_W, 0, in);
          end else begin
            state_d = prefixNext(PAT32, PAT_W, k, in);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= ST_P0;
    end else begin
      state_q <= state_d;
    end
  end

  // Every consumed bit that lands in MATCH is a new match, including
  // MATCH to MATCH; holding in MATCH with en=0 is not.
  assign matchInc = en && !clr && (state_d == ST_MATCH);

  assign out = (state_q == ST_MATCH);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk    (clk),
    .areset (areset),
    .clr    (clr),
    .inc    (matchInc),
    .count  (match_count),
    .sat    (count_sat)
  );

endmodule

// File: tb/tb_fsm_seq_det.sv
// tb_fsm_seq_det
// Three detectors share one stimulus stream:
//   A : overlapping, 8-bit counter
//   B : non-overlapping, 8-bit counter
//   C : overlapping, 2-bit counter (saturates quickly)
// The driver pushes the expected post-edge outputs of all three into a queue;
// the monitor pops one entry after every rising edge and compares.
module tb_fsm_seq_det;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic       inBit = 1'b0;

  logic       outA, outB, outC;
  logic [7:0] cntA, cntB;
  logic [1:0] cntC;
  logic       satA, satB, satC;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fsm_seq_det #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dutA (
    .clk(clk), .areset(areset), .en(en), .clr(clr), .in(inBit),
    .out(outA), .match_count(cntA), .count_sat(satA));

  fsm_seq_det #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dutB (
    .clk(clk), .areset(areset), .en(en), .clr(clr), .in(inBit),
    .out(outB), .match_count(cntB), .count_sat(satB));

  fsm_seq_det #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dutC (
    .clk(clk), .areset(areset), .en(en), .clr(clr), .in(inBit),
    .out(outC), .match_count(cntC), .count_sat(satC));

  typedef struct packed {
    logic [2:0] o;
    logic [2:0] s;
    logic [7:0] cA;
    logic [7:0] cB;
    logic [1:0] cC;
  } exp_t;

  exp_t sb[$];

  // Reference model: remembers the last four consumed bits and how many
  // bits are eligible to form a match (everything since reset/clr, or since
  // the previous match when overlap is off).
  int   hist[3];
  int   nBits[3];
  int   mCnt[3];
  logic mSat[3];
  logic mOut[3];

  function automatic int maxCnt(input int i);
    return (i == 2) ? 3 : 255;
  endfunction

  function automatic bit overlapOn(input int i);
    return (i != 1);
  endfunction

  task automatic modelStep(input logic r, input logic c, input logic e, input logic b);
    for (int i = 0; i < 3; i++) begin
      if (r || c) begin
        hist[i]  = 0;
        nBits[i] = 0;
        mCnt[i]  = 0;
        mSat[i]  = 1'b0;
        mOut[i]  = 1'b0;
      end else if (e) begin
        hist[i]  = ((hist[i] << 1) | int'(b)) & 15;
        nBits[i] = nBits[i] + 1;
        if (nBits[i] >= 4 && hist[i] == 11) begin
          mOut[i] = 1'b1;
          if (mCnt[i] == maxCnt(i)) mSat[i] = 1'b1;
          else mCnt[i] = mCnt[i] + 1;
          if (!overlapOn(i)) nBits[i] = 0;
          else if (nBits[i] > 100) nBits[i] = 4;
        end else begin
          mOut[i] = 1'b0;
        end
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the
  // outputs must look like after the following rising edge.
  task automatic applyStimulus(input logic r, input logic c, input logic e, input logic b);
    exp_t x;
    @(negedge clk);
    areset = r;
    clr    = c;
    en     = e;
    inBit  = b;
    modelStep(r, c, e, b);
    x.o  = {mOut[2], mOut[1], mOut[0]};
    x.s  = {mSat[2], mSat[1], mSat[0]};
    x.cA = 8'(mCnt[0]);
    x.cB = 8'(mCnt[1]);
    x.cC = 2'(mCnt[2]);
    sb.push_back(x);
  endtask

  task automatic applyBits(input logic [15:0] bits, input int n);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b0, 1'b0, 1'b1, v[i]);
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checkOutput("outA", 32'(outA), 32'(x.o[0]));
        checkOutput("outB", 32'(outB), 32'(x.o[1]));
        checkOutput("outC", 32'(outC), 32'(x.o[2]));
        checkOutput("cntA", 32'(cntA), 32'(x.cA));
        checkOutput("cntB", 32'(cntB), 32'(x.cB));
        checkOutput("cntC", 32'(cntC), 32'(x.cC));
        checkOutput("satA", 32'(satA), 32'(x.s[0]));
        checkOutput("satB", 32'(satB), 32'(x.s[1]));
        checkOutput("satC", 32'(satC), 32'(x.s[2]));
      end
    end
  end

  initial begin : driver
    int guard;
    for (int i = 0; i < 3; i++) begin
      hist[i] = 0; nBits[i] = 0; mCnt[i] = 0; mSat[i] = 1'b0; mOut[i] = 1'b0;
    end

    // reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);

    // overlap / non-overlap stream: 1011011 then 1011
    applyBits(16'b1011011, 7);
    applyBits(16'b1011, 4);

    // enable gating: 1,0 then three idle cycles with in toggling, then 1,1
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyBits(16'b10, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyBits(16'b11, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // reset mid-pattern: 1,0,1, reset, 1 (now in P1), then 0,1,1 completes
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyBits(16'b101, 3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    applyBits(16'b1, 1);
    applyBits(16'b011, 3);

    // saturation of the 2-bit counter, then clear
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int m = 0; m < 4; m++) applyBits(16'b10110, 5);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);

    // clr on the edge that would complete a match
    applyBits(16'b101, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
